alarm_ctrl: RTL and testbench

Keypad and tick sequencer for the alarm clock. It sits between the keypad decoder and the display/alarm driver. It divides a one-second tick into the `one_minute` strobe. It collects BCD digits typed by the user and issues `load_alarm`/`load_time`, and it turns SNOOZE/STOP keys into `do_snooze`/`stop_alarm` pulses. It also drives the display-source selects (`show_alarm`, `show_keys`).

---
 rtl/alarm_pkg.sv | 32 +++
 rtl/alarm_ctrl_minute_tick.sv | 50 +++++
 rtl/alarm_ctrl.sv | 163 ++++++++++++++++
 tb/tb_alarm_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared definitions for the alarm clock keypad sequencer.
//   - keypad codes for the command keys (digits are codes 0-9)
//   - FSM state encoding
//   - bcd_time_valid(): checks that a BCD HH:MM word is a legal time of day
package alarm_pkg;

    localparam logic [3:0] KEY_ALARM  = 4'hA;
    localparam logic [3:0] KEY_TIME   = 4'hB;
    localparam logic [3:0] KEY_SNOOZE = 4'hC;
    localparam logic [3:0] KEY_STOP   = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SHOW_ALARM = 2'd1,
        ST_ENTRY      = 2'd2
    } state_t;

    // t = {tens of hours, units of hours, tens of minutes, units of minutes}
    function automatic logic bcd_time_valid(input logic [15:0] t);
        logic [3:0] th;
        logic [3:0] uh;
        logic [3:0] tm;
        logic [3:0] um;
        th = t[15:12];
        uh = t[11:8];
        tm = t[7:4];
        um = t[3:0];
        return (th <= 4'd2) && (uh <= 4'd9) && ((th < 4'd2) || (uh <= 4'd3)) &&
               (tm <= 4'd5) && (um <= 4'd9);
    endfunction

endpackage

// File: rtl/alarm_ctrl_minute_tick.sv
// minute_tick: divides the one-second tick into a one-cycle minute strobe.
//   clk, reset_n : clock, asynchronous active-low reset
//   one_second   : one-cycle tick, once per second
//   clear        : restart the count at 0; a wrap due in this cycle is dropped
//   one_minute   : registered one-cycle strobe on each wrap to 0
module minute_tick #(
    parameter int SECS_PER_MIN = 60
) (
    input  logic clk,
    input  logic reset_n,
    input  logic one_second,
    input  logic clear,
    output logic one_minute
);

    localparam int CW = $clog2(SECS_PER_MIN + 1);

    logic [CW-1:0] sec_cnt_q;
    logic [CW-1:0] sec_cnt_d;
    logic          one_minute_q;
    logic          one_minute_d;

    always_comb begin
        sec_cnt_d    = sec_cnt_q;
        one_minute_d = 1'b0;
        if (clear) begin
            sec_cnt_d = '0;
        end else if (one_second) begin
            if (sec_cnt_q == CW'(SECS_PER_MIN - 1)) begin
                sec_cnt_d    = '0;
                one_minute_d = 1'b1;
            end else begin
                sec_cnt_d = sec_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec_cnt_q    <= '0;
            one_minute_q <= 1'b0;
        end else begin
            sec_cnt_q    <= sec_cnt_d;
            one_minute_q <= one_minute_d;
        end
    end

    assign one_minute = one_minute_q;

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: keypad and tick sequencer for the alarm clock.
//   clk, reset_n          : clock, asynchronous active-low reset
//   one_second            : one-cycle second tick
//   key_valid, key[3:0]   : keypad strobe and code (0-9 digits, A-D commands)
//   alarm_ringing         : alarm currently sounding (gates SNOOZE)
//   key_buffer[15:0]      : BCD HH:MM being typed
//   load_alarm, load_time : one-cycle load pulses, key_buffer valid alongside
//   show_alarm, show_keys : display source selects
//   one_minute            : one-cycle minute strobe
//   do_snooze, stop_alarm : one-cycle command pulses
// Handshake: key_valid and one_second are single-cycle strobes with no ready;
// every strobe is consumed in the cycle it is high, responses appear one edge later.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int SECS_PER_MIN  = 60,
    parameter int ENTRY_TIMEOUT = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        one_second,
    input  logic        key_valid,
    input  logic [3:0]  key,
    input  logic        alarm_ringing,
    output logic [15:0] key_buffer,
    output logic        load_alarm,
    output logic        load_time,
    output logic        show_alarm,
    output logic        show_keys,
    output logic        one_minute,
    output logic        do_snooze,
    output logic        stop_alarm
);

    localparam int TW = $clog2(ENTRY_TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [15:0]   key_buffer_q, key_buffer_d;
    logic          clr_buf_q, clr_buf_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic          load_alarm_q, load_alarm_d;
    logic          load_time_q, load_time_d;
    logic          show_alarm_q, show_alarm_d;
    logic          show_keys_q, show_keys_d;
    logic          do_snooze_q, do_snooze_d;
    logic          stop_alarm_q, stop_alarm_d;

    logic is_digit;
    logic timeout_hit;
    logic entry_ok;

    assign is_digit = (key <= 4'd9);
    // The tick that would make the count reach ENTRY_TIMEOUT leaves at that edge.
    assign timeout_hit = one_second && (state_q != ST_IDLE) &&
                         (timeout_q >= TW'(ENTRY_TIMEOUT - 1));
    assign entry_ok = bcd_time_valid(key_buffer_q);

    always_comb begin
        state_d      = state_q;
        // Buffer is cleared one cycle after a load pulse so it is stable alongside it.
        key_buffer_d = clr_buf_q ? 16'h0000 : key_buffer_q;
        clr_buf_d    = 1'b0;
        load_alarm_d = 1'b0;
        load_time_d  = 1'b0;
        do_snooze_d  = 1'b0;
        stop_alarm_d = 1'b0;

        if (key_valid) begin
            if (key == KEY_STOP) begin
                stop_alarm_d = 1'b1;
                if (state_q == ST_ENTRY) begin
                    key_buffer_d = 16'h0000;
                    state_d      = ST_IDLE;
                end
            end else if (key == KEY_SNOOZE) begin
                do_snooze_d = alarm_ringing;
            end else begin
                case (state_q)
                    ST_IDLE, ST_SHOW_ALARM: begin
                        if (is_digit) begin
                            key_buffer_d = {12'h000, key};
                            state_d      = ST_ENTRY;
                        end else if (key == KEY_ALARM) begin
                            state_d = (state_q == ST_IDLE) ? ST_SHOW_ALARM : ST_IDLE;
                        end
                    end
                    ST_ENTRY: begin
                        if (is_digit) begin
                            key_buffer_d = {key_buffer_q[11:0], key};
                        end else if ((key == KEY_ALARM) || (key == KEY_TIME)) begin
                            load_alarm_d = entry_ok && (key == KEY_ALARM);
                            load_time_d  = entry_ok && (key == KEY_TIME);
                            clr_buf_d    = 1'b1;
                            state_d      = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else if (timeout_hit) begin
            if (state_q == ST_ENTRY) begin
                key_buffer_d = 16'h0000;
            end
            state_d = ST_IDLE;
        end

        timeout_d = timeout_q;
        if (key_valid || (state_d != state_q) || (state_q == ST_IDLE)) begin
            timeout_d = '0;
        end else if (one_second && (timeout_q < TW'(ENTRY_TIMEOUT))) begin
            timeout_d = timeout_q + 1'b1;
        end

        show_alarm_d = (state_d == ST_SHOW_ALARM);
        show_keys_d  = (state_d == ST_ENTRY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            key_buffer_q <= 16'h0000;
            clr_buf_q    <= 1'b0;
            timeout_q    <= '0;
            load_alarm_q <= 1'b0;
            load_time_q  <= 1'b0;
            show_alarm_q <= 1'b0;
            show_keys_q  <= 1'b0;
            do_snooze_q  <= 1'b0;
            stop_alarm_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_buffer_q <= key_buffer_d;
            clr_buf_q    <= clr_buf_d;
            timeout_q    <= timeout_d;
            load_alarm_q <= load_alarm_d;
            load_time_q  <= load_time_d;
            show_alarm_q <= show_alarm_d;
            show_keys_q  <= show_keys_d;
            do_snooze_q  <= do_snooze_d;
            stop_alarm_q <= stop_alarm_d;
        end
    end

    // The load_time pulse itself restarts the seconds count.
    minute_tick #(
        .SECS_PER_MIN(SECS_PER_MIN)
    ) u_minute_tick (
        .clk       (clk),
        .reset_n   (reset_n),
        .one_second(one_second),
        .clear     (load_time_q),
        .one_minute(one_minute)
    );

    assign key_buffer = key_buffer_q;
    assign load_alarm = load_alarm_q;
    assign load_time  = load_time_q;
    assign show_alarm = show_alarm_q;
    assign show_keys  = show_keys_q;
    assign do_snooze  = do_snooze_q;
    assign stop_alarm = stop_alarm_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
module tb_alarm_ctrl;
    import alarm_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        one_second;
    logic        key_valid;
    logic [3:0]  key;
    logic        alarm_ringing;
    logic [15:0] key_buffer;
    logic        load_alarm;
    logic        load_time;
    logic        show_alarm;
    logic        show_keys;
    logic        one_minute;
    logic        do_snooze;
    logic        stop_alarm;

    int n_checks = 0;
    int n_errors = 0;
    int minute_cnt = 0;

    alarm_ctrl #(
        .SECS_PER_MIN (60),
        .ENTRY_TIMEOUT(10)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .one_second   (one_second),
        .key_valid    (key_valid),
        .key          (key),
        .alarm_ringing(alarm_ringing),
        .key_buffer   (key_buffer),
        .load_alarm   (load_alarm),
        .load_time    (load_time),
        .show_alarm   (show_alarm),
        .show_keys    (show_keys),
        .one_minute   (one_minute),
        .do_snooze    (do_snooze),
        .stop_alarm   (stop_alarm)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks: inputs change and outputs are sampled 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        if (one_minute) minute_cnt++;
    endtask

    task automatic send_key(input logic [3:0] k);
        key_valid = 1'b1;
        key       = k;
        step();
        key_valid = 1'b0;
        key       = 4'h0;
    endtask

    task automatic sec();
        one_second = 1'b1;
        step();
        one_second = 1'b0;
    endtask

    function automatic logic [31:0] pulses();
        return {26'b0, load_alarm, load_time, show_alarm, show_keys, do_snooze, stop_alarm};
    endfunction

    initial begin
        reset_n       = 1'b0;
        one_second    = 1'b0;
        key_valid     = 1'b0;
        key           = 4'h0;
        alarm_ringing = 1'b0;
        step();
        step();
        check("reset_outputs", pulses(), 32'h0);
        check("reset_buffer", {16'h0, key_buffer}, 32'h0);
        check("reset_minute", {31'b0, one_minute}, 32'h0);
        check("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
        reset_n = 1'b1;
        step();

        // minute divider: first pulse right after the 60th tick
        minute_cnt = 0;
        for (int i = 0; i < 59; i++) sec();
        check("minute_before_60", minute_cnt, 0);
        sec();
        check("minute_at_60", {31'b0, one_minute}, 32'h1);
        step();
        check("minute_width", {31'b0, one_minute}, 32'h0);
        for (int i = 0; i < 60; i++) sec();
        check("minute_120_ticks", minute_cnt, 2);

        // alarm entry 07:30
        send_key(4'd0);
        check("entry_show_keys", {31'b0, show_keys}, 32'h1);
        send_key(4'd7);
        send_key(4'd3);
        send_key(4'd0);
        check("entry_buffer_0730", {16'h0, key_buffer}, 32'h0730);
        send_key(KEY_ALARM);
        check("load_alarm_pulse", {31'b0, load_alarm}, 32'h1);
        check("load_alarm_buffer", {16'h0, key_buffer}, 32'h0730);
        check("load_alarm_show_keys", {31'b0, show_keys}, 32'h0);
        step();
        check("load_alarm_width", {31'b0, load_alarm}, 32'h0);
        check("load_alarm_cleared", {16'h0, key_buffer}, 32'h0);
        check("load_alarm_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // move the seconds counter off zero so the restart is visible
        for (int i = 0; i < 25; i++) sec();

        // invalid time 25:10
        send_key(4'd2);
        send_key(4'd5);
        send_key(4'd1);
        send_key(4'd0);
        send_key(KEY_TIME);
        check("invalid_no_load", {30'b0, load_alarm, load_time}, 32'h0);
        check("invalid_idle", 32'(dut.state_q), 32'(ST_IDLE));
        step();
        check("invalid_cleared", {16'h0, key_buffer}, 32'h0);

        // five digits, oldest dropped -> 23:45
        send_key(4'd1);
        send_key(4'd2);
        send_key(4'd3);
        send_key(4'd4);
        send_key(4'd5);
        check("shift_buffer_2345", {16'h0, key_buffer}, 32'h2345);
        send_key(KEY_TIME);
        check("load_time_pulse", {31'b0, load_time}, 32'h1);
        check("load_time_buffer", {16'h0, key_buffer}, 32'h2345);
        step();
        check("load_time_width", {31'b0, load_time}, 32'h0);
        minute_cnt = 0;
        for (int i = 0; i < 59; i++) sec();
        check("restart_no_early_minute", minute_cnt, 0);
        sec();
        check("restart_minute_at_60", {31'b0, one_minute}, 32'h1);

        // snooze gating and stop in entry
        send_key(KEY_SNOOZE);
        check("snooze_not_ringing", {31'b0, do_snooze}, 32'h0);
        alarm_ringing = 1'b1;
        send_key(KEY_SNOOZE);
        check("snooze_ringing", {31'b0, do_snooze}, 32'h1);
        step();
        check("snooze_width", {31'b0, do_snooze}, 32'h0);
        alarm_ringing = 1'b0;
        send_key(4'd4);
        send_key(4'd2);
        check("pre_stop_buffer", {16'h0, key_buffer}, 32'h0042);
        send_key(KEY_STOP);
        check("stop_pulse", {31'b0, stop_alarm}, 32'h1);
        check("stop_buffer", {16'h0, key_buffer}, 32'h0);
        check("stop_show_keys", {31'b0, show_keys}, 32'h0);
        step();
        check("stop_width", {31'b0, stop_alarm}, 32'h0);

        // show alarm and timeout
        send_key(KEY_ALARM);
        check("show_alarm_on", {31'b0, show_alarm}, 32'h1);
        for (int i = 0; i < 9; i++) sec();
        check("show_alarm_9_ticks", {31'b0, show_alarm}, 32'h1);
        sec();
        check("show_alarm_timeout", {31'b0, show_alarm}, 32'h0);
        send_key(KEY_ALARM);
        for (int i = 0; i < 9; i++) sec();
        key_valid  = 1'b1;
        key        = 4'hE;
        one_second = 1'b1;
        step();
        key_valid  = 1'b0;
        one_second = 1'b0;
        check("key_beats_timeout", {31'b0, show_alarm}, 32'h1);
        for (int i = 0; i < 9; i++) sec();
        check("timeout_restarted", {31'b0, show_alarm}, 32'h1);
        sec();
        check("timeout_after_key", {31'b0, show_alarm}, 32'h0);
        send_key(KEY_ALARM);
        send_key(KEY_ALARM);
        check("alarm_toggle_off", {31'b0, show_alarm}, 32'h0);

        // entry timeout
        send_key(4'd5);
        for (int i = 0; i < 10; i++) sec();
        check("entry_timeout_show", {31'b0, show_keys}, 32'h0);
        check("entry_timeout_buffer", {16'h0, key_buffer}, 32'h0);

        // asynchronous reset mid-entry, with a load pulse in flight
        send_key(4'd1);
        send_key(4'd2);
        check("pre_reset_buffer", {16'h0, key_buffer}, 32'h0012);
        send_key(KEY_ALARM);
        check("pre_reset_load", {31'b0, load_alarm}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("async_reset_buffer", {16'h0, key_buffer}, 32'h0);
        check("async_reset_pulses", pulses(), 32'h0);
        check("async_reset_state", 32'(dut.state_q), 32'(ST_IDLE));
        step();
        reset_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
